modular_multiply: RTL and testbench

- Sequential interleaved (MSB-first, shift-and-add) modular multiplier: computes prod = (a·b) mod base over WIDTH-bit operands, one multiplier bit per cycle.
- Companion to the modular inverse block in the RSA key/crypto path.
- Its immediate use is checking inverses: result == 1 ⇔ b is the inverse of a mod base. The same block later serves as the multiply primitive for modular exponentiation.
- Also flags prod == 1 directly (is_one_out).

---
 rtl/modmul_pkg.sv | 4 +
 rtl/mod_mul_step.sv | 23 ++
 rtl/modular_multiply.sv | 105 ++++++++++
 tb/tb_modular_multiply.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/modmul_pkg.sv
// Shared types for the modular multiplier and its step datapath.
package modmul_pkg;
  typedef enum logic [1:0] {IDLE, CHECK, ITER, DONE} state_t;
endpackage

// File: rtl/mod_mul_step.sv
// One MSB-first interleaved step: acc_next = (2*acc + bit_in*a) mod n.
// Purely combinational; operands must satisfy acc, a < n.
module mod_mul_step #(
  parameter int WIDTH = 512
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] n,
  input  logic             bit_in,
  output logic [WIDTH:0]   acc_next
);
  logic [WIDTH:0] n_ext, a_ext, dbl, red, sum;

  // With acc < n the doubled value and the sum stay below 2*n, so WIDTH+1 bits never overflow.
  always_comb begin
    n_ext    = {1'b0, n};
    a_ext    = {1'b0, a};
    dbl      = acc << 1;
    red      = (dbl >= n_ext) ? dbl - n_ext : dbl;
    sum      = bit_in ? red + a_ext : red;
    acc_next = (sum >= n_ext) ? sum - n_ext : sum;
  end
endmodule

// File: rtl/modular_multiply.sv
// Sequential (a*b) mod base, one multiplier bit per cycle; result WIDTH+2 edges after accept.
// No input queueing: valid_in is ignored while busy_out is high, including the result cycle.
module modular_multiply
  import modmul_pkg::*;
#(
  parameter int WIDTH = 512
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] base,
  input  logic             valid_in,
  output logic [WIDTH-1:0] prod_out,
  output logic             valid_out,
  output logic             is_one_out,
  output logic             busy_out,
  output logic             error_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_r, b_r, n_r;
  logic [WIDTH:0]   acc, acc_next;
  logic [CW-1:0]    cnt;
  logic             err_r;
  logic             accept;
  logic             operands_bad;

  assign operands_bad = (n_r < WIDTH'(2)) || (a_r >= n_r) || (b_r >= n_r);

  // Outputs are registered out of DONE, so the pulse cycle itself still counts as busy.
  assign busy_out = (state_q != IDLE) || valid_out;

  mod_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .a        (a_r),
    .n        (n_r),
    .bit_in   (b_r[cnt]),
    .acc_next (acc_next)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid_in && !valid_out) begin
          accept  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK:   state_d = operands_bad ? DONE : ITER;
      ITER:    if (cnt == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      a_r   <= '0;
      b_r   <= '0;
      n_r   <= '0;
      acc   <= '0;
      cnt   <= '0;
      err_r <= 1'b0;
    end else begin
      if (accept) begin
        a_r   <= a_in;
        b_r   <= b_in;
        n_r   <= base;
        acc   <= '0;
        cnt   <= CW'(WIDTH - 1);
        err_r <= 1'b0;
      end
      if (state_q == CHECK) err_r <= operands_bad;
      if (state_q == ITER) begin
        acc <= acc_next;
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      prod_out   <= '0;
      valid_out  <= 1'b0;
      is_one_out <= 1'b0;
      error_out  <= 1'b0;
    end else begin
      valid_out <= (state_q == DONE);
      error_out <= (state_q == DONE) && err_r;
      if (state_q == DONE) begin
        prod_out   <= err_r ? '0 : acc[WIDTH-1:0];
        is_one_out <= !err_r && (acc == (WIDTH + 1)'(1));
      end
    end
  end
endmodule

// File: tb/tb_modular_multiply.sv
// Drives 8-, 16- and 512-bit instances; expected results come from plain modular arithmetic.
module tb_modular_multiply;
  logic clk, rst;

  logic [7:0]   a8, b8, n8, p8;
  logic         v8, vo8, one8, busy8, err8;
  logic [15:0]  a16, b16, n16, p16;
  logic         v16, vo16, one16, busy16, err16;
  logic [511:0] a512, b512, n512, p512;
  logic         v512, vo512, one512, busy512, err512;

  int tests = 0;
  int fails = 0;

  modular_multiply #(.WIDTH(8)) u8 (
    .clk_in(clk), .rst_in(rst), .a_in(a8), .b_in(b8), .base(n8), .valid_in(v8),
    .prod_out(p8), .valid_out(vo8), .is_one_out(one8), .busy_out(busy8), .error_out(err8));
  modular_multiply #(.WIDTH(16)) u16 (
    .clk_in(clk), .rst_in(rst), .a_in(a16), .b_in(b16), .base(n16), .valid_in(v16),
    .prod_out(p16), .valid_out(vo16), .is_one_out(one16), .busy_out(busy16), .error_out(err16));
  modular_multiply #(.WIDTH(512)) u512 (
    .clk_in(clk), .rst_in(rst), .a_in(a512), .b_in(b512), .base(n512), .valid_in(v512),
    .prod_out(p512), .valid_out(vo512), .is_one_out(one512), .busy_out(busy512), .error_out(err512));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic sel_vld(input int w);
    case (w) 8: return vo8; 16: return vo16; default: return vo512; endcase
  endfunction
  function automatic logic sel_busy(input int w);
    case (w) 8: return busy8; 16: return busy16; default: return busy512; endcase
  endfunction
  function automatic logic sel_one(input int w);
    case (w) 8: return one8; 16: return one16; default: return one512; endcase
  endfunction
  function automatic logic sel_err(input int w);
    case (w) 8: return err8; 16: return err16; default: return err512; endcase
  endfunction
  function automatic logic [511:0] sel_prod(input int w);
    case (w) 8: return {504'd0, p8}; 16: return {496'd0, p16}; default: return p512; endcase
  endfunction

  task automatic drive(input int w, input logic [511:0] a, b, n, input logic v);
    case (w)
      8:       begin a8 = a[7:0];   b8 = b[7:0];   n8 = n[7:0];   v8 = v;   end
      16:      begin a16 = a[15:0]; b16 = b[15:0]; n16 = n[15:0]; v16 = v;  end
      default: begin a512 = a;      b512 = b;      n512 = n;      v512 = v; end
    endcase
  endtask

  // One request; lat = edges from the accepting edge to the valid_out cycle, -1 on timeout.
  task automatic run_op(input int w, input logic [511:0] a, b, n, output int lat,
                        output logic [511:0] p, output logic one, output logic err,
                        output logic busy_ok);
    lat = -1; p = '0; one = 1'b0; err = 1'b0; busy_ok = 1'b1;
    @(negedge clk);
    drive(w, a, b, n, 1'b1);
    @(posedge clk);
    #1 drive(w, ~a, ~b, ~n, 1'b0);
    for (int j = 0; j < 700; j++) begin
      @(negedge clk);
      if (!sel_busy(w)) busy_ok = 1'b0;
      if (sel_vld(w)) begin
        lat = j; p = sel_prod(w); one = sel_one(w); err = sel_err(w);
        break;
      end
      @(posedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(8, '0, '0, '0, 1'b0);
    drive(16, '0, '0, '0, 1'b0);
    drive(512, '0, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    tests++; if ({vo8, busy8, err8, one8} !== 4'b0) begin fails++; $display("FAIL reset_ctrl8: got %b expected 0000", {vo8, busy8, err8, one8}); end
    tests++; if (p8 !== 8'd0) begin fails++; $display("FAIL reset_prod8: got %0d expected 0", p8); end
    tests++; if ({vo512, busy512, err512, one512} !== 4'b0) begin fails++; $display("FAIL reset_ctrl512: got %b expected 0000", {vo512, busy512, err512, one512}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat; logic [511:0] p; logic one, err, bok;
    run_op(8, 512'd3, 512'd5, 512'd7, lat, p, one, err, bok);
    tests++; if (lat !== 10) begin fails++; $display("FAIL basic_latency: got %0d expected 10", lat); end
    tests++; if (p !== 512'd1) begin fails++; $display("FAIL basic_prod: got %0d expected 1", p[7:0]); end
    tests++; if ({one, err} !== 2'b10) begin fails++; $display("FAIL basic_flags: one/err got %b expected 10", {one, err}); end
    tests++; if (bok !== 1'b1) begin fails++; $display("FAIL basic_busy: busy dropped during operation"); end
    @(negedge clk);
    tests++; if ({vo8, err8, busy8} !== 3'b000) begin fails++; $display("FAIL basic_pulse: vld/err/busy got %b expected 000", {vo8, err8, busy8}); end
    tests++; if ({p8, one8} !== {8'd1, 1'b1}) begin fails++; $display("FAIL basic_hold: prod/one got %0d/%b expected 1/1", p8, one8); end
  endtask

  task automatic test_arith;
    int lat; logic [511:0] p; logic one, err, bok;
    run_op(8, 512'd0, 512'd200, 512'd251, lat, p, one, err, bok);
    tests++; if (p !== 512'd0 || one !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL zero_operand: prod %0d one %b err %b expected 0 0 0", p[7:0], one, err); end
    run_op(8, 512'd4, 512'd5, 512'd13, lat, p, one, err, bok);
    tests++; if (p !== 512'd7 || one !== 1'b0) begin fails++; $display("FAIL arith_4x5m13: prod %0d one %b expected 7 0", p[7:0], one); end
    tests++; if (lat !== 10) begin fails++; $display("FAIL arith_latency: got %0d expected 10", lat); end
  endtask

  task automatic test_errors;
    int lat; logic [511:0] p; logic one, err, bok;
    logic [7:0] ea [3]; logic [7:0] eb [3]; logic [7:0] en [3];
    ea = '{8'd0, 8'd9, 8'd3}; eb = '{8'd0, 8'd2, 8'd7}; en = '{8'd1, 8'd7, 8'd7};
    for (int i = 0; i < 3; i++) begin
      run_op(8, {504'd0, ea[i]}, {504'd0, eb[i]}, {504'd0, en[i]}, lat, p, one, err, bok);
      tests++; if (err !== 1'b1) begin fails++; $display("FAIL error_flag[%0d]: got %b expected 1", i, err); end
      tests++; if (lat !== 2) begin fails++; $display("FAIL error_latency[%0d]: got %0d expected 2", i, lat); end
      tests++; if (p !== 512'd0 || one !== 1'b0) begin fails++; $display("FAIL error_prod[%0d]: prod %0d one %b expected 0 0", i, p[7:0], one); end
    end
    @(negedge clk);
    tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL error_pulse: got %b expected 0", err8); end
  endtask

  task automatic test_wide;
    int lat; logic [511:0] p, n, bh; logic one, err, bok;
    n  = (512'd1 << 511) + 512'd187;
    run_op(512, n - 512'd1, n - 512'd1, n, lat, p, one, err, bok);
    tests++; if (p !== 512'd1 || one !== 1'b1 || err !== 1'b0) begin fails++; $display("FAIL wide_minus1_sq: prod %0h one %b err %b expected 1 1 0", p, one, err); end
    tests++; if (lat !== 514) begin fails++; $display("FAIL wide_latency: got %0d expected 514", lat); end
    bh = (n + 512'd1) >> 1;
    run_op(512, 512'd2, bh, n, lat, p, one, err, bok);
    tests++; if (p !== 512'd1 || one !== 1'b1) begin fails++; $display("FAIL wide_half_inverse: prod %0h one %b expected 1 1", p, one); end
  endtask

  task automatic test_ignore_busy;
    int lat; int extra;
    lat = -1; extra = 0;
    @(negedge clk);
    drive(8, 512'd4, 512'd5, 512'd13, 1'b1);
    @(posedge clk);
    #1 drive(8, '0, '0, '0, 1'b0);
    for (int j = 0; j < 100; j++) begin
      @(negedge clk);
      if (j == 4) drive(8, 512'd2, 512'd3, 512'd11, 1'b1);
      else if (j == 5) drive(8, '0, '0, '0, 1'b0);
      if (vo8) begin lat = j; break; end
      @(posedge clk);
    end
    tests++; if (lat !== 10) begin fails++; $display("FAIL ignore_latency: got %0d expected 10", lat); end
    tests++; if (p8 !== 8'd7) begin fails++; $display("FAIL ignore_prod: got %0d expected 7", p8); end
    for (int j = 0; j < 15; j++) begin @(negedge clk); if (vo8) extra++; end
    tests++; if (extra !== 0) begin fails++; $display("FAIL ignore_queued: got %0d extra results expected 0", extra); end
  endtask

  task automatic test_reset_mid;
    int lat; int stray; logic [511:0] p; logic one, err, bok;
    stray = 0;
    @(negedge clk);
    drive(8, 512'd4, 512'd5, 512'd13, 1'b1);
    @(posedge clk);
    #1 drive(8, '0, '0, '0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if ({p8, vo8, busy8, one8} !== 11'd0) begin fails++; $display("FAIL reset_mid_outputs: prod %0d vld %b busy %b one %b expected all 0", p8, vo8, busy8, one8); end
    @(negedge clk);
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin @(negedge clk); if (vo8) stray++; end
    tests++; if (stray !== 0) begin fails++; $display("FAIL reset_mid_stray: got %0d valid pulses expected 0", stray); end
    run_op(8, 512'd3, 512'd5, 512'd7, lat, p, one, err, bok);
    tests++; if (p !== 512'd1 || lat !== 10) begin fails++; $display("FAIL reset_mid_recover: prod %0d lat %0d expected 1 10", p[7:0], lat); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, n;
    longint expv;
    logic got;
    n = 16'($urandom_range(65535, 2)); a = 16'($urandom % n); b = 16'($urandom % n);
    @(negedge clk);
    drive(16, {496'd0, a}, {496'd0, b}, {496'd0, n}, 1'b1);
    for (int i = 0; i < 1000; i++) begin
      expv = (longint'(a) * longint'(b)) % longint'(n);
      got = 1'b0;
      for (int j = 0; j < 100; j++) begin
        @(posedge clk); @(negedge clk);
        if (vo16) begin got = 1'b1; break; end
      end
      tests++;
      if (!got) begin
        fails++; $display("FAIL b2b_timeout[%0d]: got no valid_out expected one within 100 cycles", i);
        break;
      end
      if (longint'(p16) !== expv || one16 !== (expv == 1) || err16 !== 1'b0) begin
        fails++;
        $display("FAIL b2b_result[%0d] %0d*%0d mod %0d: got %0d one %b err %b expected %0d", i, a, b, n, p16, one16, err16, expv);
      end
      n = 16'($urandom_range(65535, 2));
      if (i % 10 == 3) begin a = n - 16'd1; b = n - 16'd1; end
      else begin a = 16'($urandom % n); b = 16'($urandom % n); end
      drive(16, {496'd0, a}, {496'd0, b}, {496'd0, n}, i < 999);
    end
    v16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_arith();
    test_errors();
    test_wide();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
